// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB LED sequencer: FSM states,
// the fixed eight-entry colour palette and the mode indicator encodings.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;

    localparam int N_COLORS = 8;
    localparam int IDX_BITS = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    localparam logic [1:0] LED_OFF    = 2'b00;
    localparam logic [1:0] LED_MANUAL = 2'b01;
    localparam logic [1:0] LED_AUTO   = 2'b10;
    localparam logic [1:0] LED_PAUSED = 2'b11;

    // Palette order: black, red, green, blue, yellow, cyan, magenta, white.
    function automatic color_t palette(input logic [IDX_BITS-1:0] idx);
        color_t c;
        case (idx)
            3'd1:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd3:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
            3'd4:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd5:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd6:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd7:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
        endcase
        return c;
    endfunction

    // Palette index successor, wrapping from the last colour back to black.
    function automatic logic [IDX_BITS-1:0] next_idx(input logic [IDX_BITS-1:0] idx);
        return (idx == IDX_BITS'(N_COLORS - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rgb_led_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stable-time debounce and a
// single-cycle registered pulse when the debounced level rises.
module btn_debounce #(
    parameter int DB_CYC = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has persisted DB_CYC cycles; pulse on a rising accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYC - 1)) begin
                stable <= sync_2;
                cnt    <= '0;
                press  <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer for the CMOD A7: debounced mode/act buttons drive an
// OFF/MANUAL/AUTO FSM that walks a colour palette shown on the RGB LED via PWM.
// Optional feature macro: RGB_SEQ_BREATHE_EN adds a triangle brightness ramp
// over each AUTO step period; without it duty is the raw palette value.
module rgb_led_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int CLK_HZ      = 12_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int STEP_MS     = 250,
    parameter int PWM_BITS    = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [1:0] BTN,
    output logic [1:0] LED,
    output logic       RGB0_Red,
    output logic       RGB0_Green,
    output logic       RGB0_Blue
);

    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int STEP_CYC = CLK_HZ / 1000 * STEP_MS;
    localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    logic                mode_press;
    logic                act_press;
    state_t              state;
    logic [IDX_BITS-1:0] idx;
    logic                paused;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] pwm;
    color_t              color;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] duty_g;
    logic [PWM_BITS-1:0] duty_b;

    btn_debounce #(.DB_CYC(DB_CYC)) u_mode_btn (
        .clk   (CLK),
        .rst_n (RESET_N),
        .btn   (BTN[1]),
        .press (mode_press)
    );

    btn_debounce #(.DB_CYC(DB_CYC)) u_act_btn (
        .clk   (CLK),
        .rst_n (RESET_N),
        .btn   (BTN[0]),
        .press (act_press)
    );

    // Mode FSM with palette index, AUTO dwell counter and the registered mode indicator.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_OFF;
            idx      <= '0;
            paused   <= 1'b0;
            step_cnt <= '0;
            LED      <= LED_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    if (mode_press) begin
                        state <= ST_MANUAL;
                        LED   <= LED_MANUAL;
                    end
                end
                ST_MANUAL: begin
                    if (mode_press) begin
                        state    <= ST_AUTO;
                        step_cnt <= '0;
                        paused   <= 1'b0;
                        LED      <= LED_AUTO;
                    end else if (act_press) begin
                        idx <= next_idx(idx);
                    end
                end
                ST_AUTO: begin
                    if (mode_press) begin
                        state <= ST_OFF;
                        LED   <= LED_OFF;
                    end else begin
                        if (!paused) begin
                            if (step_cnt == STEP_W'(STEP_CYC - 1)) begin
                                step_cnt <= '0;
                                idx      <= next_idx(idx);
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                        if (act_press) begin
                            paused <= !paused;
                            LED    <= paused ? LED_AUTO : LED_PAUSED;
                        end
                    end
                end
                default: begin
                    state <= ST_OFF;
                    LED   <= LED_OFF;
                end
            endcase
        end
    end

    // Free-running PWM phase shared by all three channels.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + 1'b1;
        end
    end

`ifdef RGB_SEQ_BREATHE_EN
    localparam int B_MAX = (1 << PWM_BITS) - 1;
    localparam int HALF  = (STEP_CYC / 2 > 0) ? STEP_CYC / 2 : 1;

    logic [PWM_BITS-1:0] bright;

    function automatic logic [PWM_BITS-1:0] ramp(input logic [STEP_W-1:0] pos);
        int p;
        int v;
        p = int'(pos);
        if (p < HALF) begin
            v = p * B_MAX / HALF;
        end else begin
            v = (STEP_CYC - 1 - p) * B_MAX / HALF;
        end
        if (v > B_MAX) begin
            v = B_MAX;
        end
        if (v < 0) begin
            v = 0;
        end
        return PWM_BITS'(v);
    endfunction

    function automatic logic [PWM_BITS-1:0] scale(input logic [7:0] ch,
                                                   input logic [PWM_BITS-1:0] b);
        return PWM_BITS'((int'(ch) * int'(b)) >> PWM_BITS);
    endfunction

    // Sample the triangle brightness once per PWM period while AUTO is running.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bright <= '0;
        end else if (state == ST_AUTO && !paused && pwm == '1) begin
            bright <= ramp(step_cnt);
        end
    end
`endif

    // Channel duty from the current palette entry; dark whenever the sequencer is off.
    always_comb begin
        color  = palette(idx);
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        if (state != ST_OFF) begin
            duty_r = PWM_BITS'(color.r);
            duty_g = PWM_BITS'(color.g);
            duty_b = PWM_BITS'(color.b);
        end
`ifdef RGB_SEQ_BREATHE_EN
        if (state == ST_AUTO) begin
            duty_r = scale(color.r, bright);
            duty_g = scale(color.g, bright);
            duty_b = scale(color.b, bright);
        end
`endif
    end

    // Registered active-low channel drive: lit while the PWM phase is below the duty.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RGB0_Red   <= 1'b1;
            RGB0_Green <= 1'b1;
            RGB0_Blue  <= 1'b1;
        end else begin
            RGB0_Red   <= !(pwm < duty_r);
            RGB0_Green <= !(pwm < duty_g);
            RGB0_Blue  <= !(pwm < duty_b);
        end
    end

endmodule
